// File: rtl/axi_burst_master.sv
// Single-command AXI-style burst initiator: one INCR/FIXED write or read burst
// at a time, with client-side write/read streams and a done/err status pulse.
module axi_burst_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  cmd_burst,
  input  logic [DATA_WIDTH-1:0] wd_data,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done,
  output logic                  err,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWBURST,
  output logic [7:0]            AWLEN,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARBURST,
  output logic [7:0]            ARLEN,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST
);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic                  burst_q;
  logic                  err_q;
  logic                  is_last;
  logic                  w_hs;
  logic                  r_hs;

  assign is_last = (cnt_q == len_q - 8'd1);
  assign w_hs    = (state == W) && wd_valid && WREADY;
  assign r_hs    = (state == R) && RVALID && rd_ready;

  // The master only issues the start address; burst address generation is the slave's job.
  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWBURST = burst_q;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARBURST = burst_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (cmd_valid) begin
          addr_q  <= cmd_addr;
          len_q   <= cmd_len;
          burst_q <= cmd_burst;
          cnt_q   <= '0;
          err_q   <= (cmd_len == 8'd0);
        end
        W: if (w_hs) cnt_q <= cnt_q + 8'd1;
        B: if (BVALID) err_q <= err_q | (BRESP != 2'b00);
        // A RLAST that disagrees with our own beat count is flagged but never shortens the burst.
        R: if (r_hs) begin
          cnt_q <= cnt_q + 8'd1;
          err_q <= err_q | (RRESP != 2'b00) | (RLAST != is_last);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    WDATA     = '0;
    WLAST     = 1'b0;
    wd_ready  = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    rd_last   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_len == 8'd0) ? DONE : (cmd_write ? AW : AR);
      end
      AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_nxt = W;
      end
      W: begin
        WVALID   = wd_valid;
        WDATA    = wd_data;
        wd_ready = WREADY;
        WLAST    = is_last;
        if (w_hs && is_last) state_nxt = B;
      end
      B: begin
        BREADY = 1'b1;
        if (BVALID) state_nxt = DONE;
      end
      AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = R;
      end
      R: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        rd_data  = RDATA;
        rd_last  = is_last;
        if (r_hs && is_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: behavioural RAM slave plus a reference memory
// model built from the commands the client issues.
module tb_axi_burst_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_burst;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wd_data, rd_data;
  logic        wd_valid, wd_ready, rd_valid, rd_last, rd_ready, done, err;
  logic        AWVALID, AWREADY, AWBURST, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic        ARVALID, ARREADY, ARBURST, RVALID, RREADY, RLAST;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;
  logic [124:0] outs;

  axi_burst_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
    .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready), .done(done), .err(err),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWBURST(AWBURST), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARBURST(ARBURST), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
  );

  assign outs = {AWVALID, AWADDR, AWBURST, AWLEN, WVALID, WDATA, WLAST, BREADY, ARVALID,
                 ARADDR, ARBURST, ARLEN, RREADY, wd_ready, rd_data, rd_valid, rd_last, done, err};

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;
  logic [31:0] smem [0:65535];
  logic [31:0] rmem [int];
  logic [31:0] wdata_q[$];
  logic [31:0] wq[$], rq[$];
  bit          wlq[$], rlq[$];
  int aw_seen, ar_seen, aw_hs, ar_hs, acc_cyc;
  logic [15:0] aw_addr_s, ar_addr_s;
  logic [7:0]  aw_len_s, ar_len_s;
  logic        aw_burst_s, ar_burst_s;
  int aw_delay, ar_delay, rlast_beat, rd_hold_at, rst_at_beat;
  bit w_toggle, rnd, rst_hit;
  logic [1:0] bresp_v;

  function automatic logic [31:0] init_val(int a);
    return 32'hC0DE0000 ^ 32'(a * 7);
  endfunction

  function automatic logic [31:0] exp_mem(int a);
    return rmem.exists(a) ? rmem[a] : init_val(a);
  endfunction

  task automatic defaults();
    aw_delay = 0; ar_delay = 0; w_toggle = 0; rnd = 0; bresp_v = 2'b00;
    rlast_beat = -1; rd_hold_at = -1; rst_at_beat = -1;
  endtask

  // Runs one command from cmd offer to the IDLE cycle after done, acting as client and RAM slave.
  task automatic run_cmd(input bit wr, input logic [15:0] a, input logic [7:0] l, input bit bu,
                         output bit got_done, output bit got_err, output int lat);
    int wi, sw, rs, aw_wait, ar_wait, hold, idx;
    bit acc, bpend, ract, rv, wv, pawv, pawr, pwv, pwr, parv, parr, pwl;
    logic [15:0] paw_a, par_a;
    logic [31:0] pwd;
    wi = 0; sw = 0; rs = 0; aw_wait = 0; ar_wait = 0; hold = 0;
    acc = 0; bpend = 0; ract = 0; rv = 0; wv = 0;
    pawv = 0; pawr = 0; pwv = 0; pwr = 0; parv = 0; parr = 0; pwl = 0;
    paw_a = '0; par_a = '0; pwd = '0;
    got_done = 0; got_err = 0; lat = -1; acc_cyc = -1; rst_hit = 0;
    wq.delete(); rq.delete(); wlq.delete(); rlq.delete();
    aw_seen = 0; ar_seen = 0; aw_hs = 0; ar_hs = 0;
    if (wr) for (int i = 0; i < int'(l); i++) rmem[bu ? (int'(a) + i) % 65536 : int'(a)] = wdata_q[i];
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_burst = bu;
    for (int cyc = 0; cyc < 600 && !got_done; cyc++) begin
      AWREADY = AWVALID && (aw_wait >= aw_delay);
      ARREADY = ARVALID && (ar_wait >= ar_delay);
      if (!wv) wv = (wi < wdata_q.size()) && (!rnd || $urandom_range(0, 3) != 0);
      wd_valid = wv;
      wd_data  = wv ? wdata_q[wi] : $urandom;
      WREADY   = w_toggle ? cyc[0] : (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      BVALID   = bpend;
      BRESP    = bpend ? bresp_v : 2'b00;
      if (!rv) rv = ract && (rs < int'(l)) && (!rnd || $urandom_range(0, 2) != 0);
      idx      = bu ? (int'(a) + rs) % 65536 : int'(a);
      RVALID   = rv;
      RDATA    = rv ? smem[idx] : $urandom;
      RLAST    = rv && ((rlast_beat < 0) ? (rs == int'(l) - 1) : (rs == rlast_beat));
      RRESP    = 2'b00;
      rd_ready = !(rq.size() == rd_hold_at && hold < 2) && (!rnd || $urandom_range(0, 3) != 0);
      #1;
      if (rst_at_beat >= 0 && WVALID && wi == rst_at_beat) begin
        ARESETn = 0; rst_hit = 1; #1;
        break;
      end
      if (cmd_valid && cmd_ready && !acc) begin acc = 1; acc_cyc = cyc; end
      if (pawv && !pawr) begin
        total++;
        if (AWVALID !== 1'b1 || AWADDR !== paw_a) begin
          bad++; $display("FAIL aw_stable: valid=%b addr=%h required valid=1 addr=%h", AWVALID, AWADDR, paw_a);
        end
      end
      if (pwv && !pwr) begin
        total++;
        if (WVALID !== 1'b1 || WDATA !== pwd || WLAST !== pwl) begin
          bad++; $display("FAIL w_stable: valid=%b data=%h last=%b required 1 %h %b", WVALID, WDATA, WLAST, pwd, pwl);
        end
      end
      if (parv && !parr) begin
        total++;
        if (ARVALID !== 1'b1 || ARADDR !== par_a) begin
          bad++; $display("FAIL ar_stable: valid=%b addr=%h required valid=1 addr=%h", ARVALID, ARADDR, par_a);
        end
      end
      pawv = AWVALID; pawr = AWREADY; paw_a = AWADDR;
      pwv = WVALID; pwr = WREADY; pwd = WDATA; pwl = WLAST;
      parv = ARVALID; parr = ARREADY; par_a = ARADDR;
      if (AWVALID) begin aw_seen++; aw_wait++; end
      if (AWVALID && AWREADY) begin aw_hs++; aw_addr_s = AWADDR; aw_len_s = AWLEN; aw_burst_s = AWBURST; end
      if (ARVALID) begin ar_seen++; ar_wait++; end
      if (ARVALID && ARREADY) begin ar_hs++; ar_addr_s = ARADDR; ar_len_s = ARLEN; ar_burst_s = ARBURST; ract = 1; end
      if (wd_valid && wd_ready) begin wi++; wv = 0; end
      if (WVALID && WREADY) begin
        wq.push_back(WDATA); wlq.push_back(WLAST);
        smem[bu ? (int'(a) + sw) % 65536 : int'(a)] = WDATA;
        sw++;
        if (WLAST) bpend = 1;
      end
      if (BVALID && BREADY) bpend = 0;
      if (RVALID && RREADY) begin rs++; rv = 0; end
      if (rd_valid && rd_ready) begin rq.push_back(rd_data); rlq.push_back(rd_last); end
      else if (rd_valid && rq.size() == rd_hold_at) hold++;
      if (done) begin got_done = 1; got_err = err; lat = cyc; end
      @(posedge ACLK);
      @(negedge ACLK);
      if (acc) cmd_valid = 0;
    end
    cmd_valid = 0; wd_valid = 0; AWREADY = 0; ARREADY = 0; WREADY = 0;
    BVALID = 0; RVALID = 0; RLAST = 0; rd_ready = 0;
  endtask

  task automatic test_reset();
    ARESETn = 0; cmd_valid = 0; wd_data = 32'hDEADBEEF; RDATA = 32'hFFFFFFFF; wd_valid = 1;
    repeat (3) @(negedge ACLK);
    total++;
    if (outs !== '0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_outputs: outs=%h cmd_ready=%b required 0 and 1", outs, cmd_ready);
    end
    cmd_valid = 1; cmd_write = 1; cmd_len = 8'd5; cmd_addr = 16'h1234;
    @(negedge ACLK);
    total++;
    if (outs !== '0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_hold: outs=%h cmd_ready=%b required 0 and 1", outs, cmd_ready);
    end
    cmd_valid = 0; wd_valid = 0;
    ARESETn = 1;
    @(negedge ACLK);
  endtask

  task automatic test_write_basic();
    bit d, e; int lat;
    defaults();
    wdata_q.delete();
    for (int i = 0; i < 10; i++) wdata_q.push_back(32'(5 + i));
    run_cmd(1, 16'h0005, 8'd10, 1, d, e, lat);
    total++; if (d !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL wr_status: done=%b err=%b required 1 0", d, e); end
    total++; if (lat != 13 || acc_cyc != 0) begin bad++; $display("FAIL wr_latency: done_cyc=%0d accept_cyc=%0d required 13 0", lat, acc_cyc); end
    total++; if (aw_hs != 1 || aw_addr_s !== 16'h0005 || aw_len_s !== 8'd10 || aw_burst_s !== 1'b1) begin
      bad++; $display("FAIL wr_aw: hs=%0d addr=%h len=%0d burst=%b required 1 0005 10 1", aw_hs, aw_addr_s, aw_len_s, aw_burst_s);
    end
    total++; if (wq.size() != 10) begin bad++; $display("FAIL wr_beats: got %0d required 10", wq.size()); end
    for (int i = 0; i < 10 && i < wq.size(); i++) begin
      total++;
      if (wq[i] !== 32'(5 + i) || wlq[i] !== (i == 9)) begin
        bad++; $display("FAIL wr_beat[%0d]: data=%h last=%b required %h %b", i, wq[i], wlq[i], 32'(5 + i), (i == 9));
      end
    end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL wr_done_pulse: done=%b one cycle later, required 0", done); end
  endtask

  task automatic test_read_basic();
    bit d, e; int lat;
    defaults();
    run_cmd(0, 16'h0005, 8'd10, 1, d, e, lat);
    total++; if (d !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL rd_status: done=%b err=%b required 1 0", d, e); end
    total++; if (lat != 12 || acc_cyc != 0) begin bad++; $display("FAIL rd_latency: done_cyc=%0d accept_cyc=%0d required 12 0", lat, acc_cyc); end
    total++; if (ar_hs != 1 || ar_addr_s !== 16'h0005 || ar_len_s !== 8'd10 || ar_burst_s !== 1'b1 || aw_seen != 0) begin
      bad++; $display("FAIL rd_ar: hs=%0d addr=%h len=%0d burst=%b aw=%0d required 1 0005 10 1 0", ar_hs, ar_addr_s, ar_len_s, ar_burst_s, aw_seen);
    end
    total++; if (rq.size() != 10) begin bad++; $display("FAIL rd_beats: got %0d required 10", rq.size()); end
    for (int i = 0; i < 10 && i < rq.size(); i++) begin
      total++;
      if (rq[i] !== 32'(5 + i) || rlq[i] !== (i == 9)) begin
        bad++; $display("FAIL rd_beat[%0d]: data=%h last=%b required %h %b", i, rq[i], rlq[i], 32'(5 + i), (i == 9));
      end
    end
  endtask

  task automatic test_stall();
    bit d, e; int lat;
    defaults();
    aw_delay = 3; ar_delay = 2; w_toggle = 1; rd_hold_at = 4;
    wdata_q.delete();
    for (int i = 0; i < 10; i++) wdata_q.push_back(32'(5 + i));
    run_cmd(1, 16'h0100, 8'd10, 1, d, e, lat);
    total++; if (d !== 1'b1 || e !== 1'b0 || aw_seen != 4) begin
      bad++; $display("FAIL stall_wr: done=%b err=%b aw_cycles=%0d required 1 0 4", d, e, aw_seen);
    end
    total++; if (wq.size() != 10) begin bad++; $display("FAIL stall_wr_beats: got %0d required 10", wq.size()); end
    for (int i = 0; i < 10 && i < wq.size(); i++) begin
      total++;
      if (wq[i] !== 32'(5 + i) || wlq[i] !== (i == 9)) begin
        bad++; $display("FAIL stall_wr_beat[%0d]: data=%h last=%b required %h %b", i, wq[i], wlq[i], 32'(5 + i), (i == 9));
      end
    end
    run_cmd(0, 16'h0100, 8'd10, 1, d, e, lat);
    total++; if (d !== 1'b1 || e !== 1'b0 || rq.size() != 10) begin
      bad++; $display("FAIL stall_rd: done=%b err=%b beats=%0d required 1 0 10", d, e, rq.size());
    end
    for (int i = 0; i < 10 && i < rq.size(); i++) begin
      total++;
      if (rq[i] !== 32'(5 + i) || rlq[i] !== (i == 9)) begin
        bad++; $display("FAIL stall_rd_beat[%0d]: data=%h last=%b required %h %b", i, rq[i], rlq[i], 32'(5 + i), (i == 9));
      end
    end
  endtask

  task automatic test_errors();
    bit d, e; int lat;
    defaults();
    bresp_v = 2'b10;
    wdata_q.delete(); wdata_q.push_back($urandom);
    run_cmd(1, 16'h0200, 8'd1, 1, d, e, lat);
    total++; if (d !== 1'b1 || e !== 1'b1) begin bad++; $display("FAIL bresp_err: done=%b err=%b required 1 1", d, e); end
    defaults();
    rlast_beat = 2;
    run_cmd(0, 16'h0005, 8'd5, 1, d, e, lat);
    total++; if (d !== 1'b1 || e !== 1'b1 || rq.size() != 5) begin
      bad++; $display("FAIL rlast_err: done=%b err=%b beats=%0d required 1 1 5", d, e, rq.size());
    end
    for (int i = 0; i < 5 && i < rq.size(); i++) begin
      total++;
      if (rq[i] !== 32'(5 + i) || rlq[i] !== (i == 4)) begin
        bad++; $display("FAIL rlast_beat[%0d]: data=%h last=%b required %h %b", i, rq[i], rlq[i], 32'(5 + i), (i == 4));
      end
    end
  endtask

  task automatic test_len_zero();
    bit d, e; int lat;
    defaults();
    wdata_q.delete(); wdata_q.push_back(32'h1);
    for (int k = 0; k < 2; k++) begin
      run_cmd(k == 0, 16'h0300, 8'd0, 1, d, e, lat);
      total++;
      if (d !== 1'b1 || e !== 1'b1 || lat != 1 || aw_seen != 0 || ar_seen != 0 || wq.size() != 0) begin
        bad++; $display("FAIL len_zero[%0d]: done=%b err=%b cyc=%0d aw=%0d ar=%0d w=%0d required 1 1 1 0 0 0",
                        k, d, e, lat, aw_seen, ar_seen, wq.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    bit d, e; int lat;
    defaults();
    for (int k = 0; k < 2; k++) begin
      wdata_q.delete(); wdata_q.push_back(32'hB0 + 32'(k)); wdata_q.push_back(32'hC0 + 32'(k));
      run_cmd(1, 16'h0400 + 16'(k * 2), 8'd2, 1, d, e, lat);
      total++;
      if (d !== 1'b1 || e !== 1'b0 || acc_cyc != 0 || lat != 5) begin
        bad++; $display("FAIL b2b[%0d]: done=%b err=%b accept_cyc=%0d done_cyc=%0d required 1 0 0 5", k, d, e, acc_cyc, lat);
      end
    end
  endtask

  task automatic test_random();
    bit d, e, bu; int lat; logic [15:0] a; logic [7:0] l; logic [31:0] x;
    defaults();
    rnd = 1;
    for (int t = 0; t < 6; t++) begin
      a = 16'h1000 + 16'($urandom_range(0, 200));
      l = 8'($urandom_range(1, 16));
      bu = ($urandom_range(0, 3) != 0);
      aw_delay = int'($urandom_range(0, 3)); ar_delay = int'($urandom_range(0, 3));
      wdata_q.delete();
      for (int i = 0; i < int'(l); i++) wdata_q.push_back($urandom);
      run_cmd(1, a, l, bu, d, e, lat);
      total++; if (d !== 1'b1 || e !== 1'b0 || wq.size() != int'(l)) begin
        bad++; $display("FAIL rnd_wr[%0d]: done=%b err=%b beats=%0d required 1 0 %0d", t, d, e, wq.size(), l);
      end
      for (int i = 0; i < int'(l) && i < wq.size(); i++) begin
        total++;
        if (wq[i] !== wdata_q[i] || wlq[i] !== (i == int'(l) - 1)) begin
          bad++; $display("FAIL rnd_wr_beat[%0d.%0d]: data=%h last=%b required %h %b", t, i, wq[i], wlq[i], wdata_q[i], (i == int'(l) - 1));
        end
      end
      run_cmd(0, a, l, bu, d, e, lat);
      total++; if (d !== 1'b1 || e !== 1'b0 || rq.size() != int'(l)) begin
        bad++; $display("FAIL rnd_rd[%0d]: done=%b err=%b beats=%0d required 1 0 %0d", t, d, e, rq.size(), l);
      end
      for (int i = 0; i < int'(l) && i < rq.size(); i++) begin
        x = exp_mem(bu ? (int'(a) + i) % 65536 : int'(a));
        total++;
        if (rq[i] !== x || rlq[i] !== (i == int'(l) - 1)) begin
          bad++; $display("FAIL rnd_rd_beat[%0d.%0d]: data=%h last=%b required %h %b", t, i, rq[i], rlq[i], x, (i == int'(l) - 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit d, e; int lat; bit seen_done;
    defaults();
    rst_at_beat = 3;
    wdata_q.delete();
    for (int i = 0; i < 10; i++) wdata_q.push_back(32'hA000 + 32'(i));
    run_cmd(1, 16'h0500, 8'd10, 1, d, e, lat);
    total++; if (rst_hit !== 1'b1 || wq.size() != 3) begin
      bad++; $display("FAIL mid_reset_reach: hit=%b beats=%0d required 1 3", rst_hit, wq.size());
    end
    total++; if (outs !== '0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset_async: outs=%h cmd_ready=%b required 0 and 1", outs, cmd_ready);
    end
    seen_done = 0;
    wd_valid = 1; WREADY = 1; AWREADY = 1; BVALID = 1;
    repeat (2) begin
      @(negedge ACLK);
      if (done || outs != '0) seen_done = 1;
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL mid_reset_quiet: activity=%b required 0", seen_done); end
    wd_valid = 0; WREADY = 0; AWREADY = 0; BVALID = 0;
    ARESETn = 1;
    @(negedge ACLK);
    rst_at_beat = -1;
    wdata_q.delete(); wdata_q.push_back(32'h600D_F00D);
    run_cmd(1, 16'h0600, 8'd1, 1, d, e, lat);
    total++; if (d !== 1'b1 || e !== 1'b0 || lat != 4 || wq.size() != 1) begin
      bad++; $display("FAIL post_reset_wr: done=%b err=%b cyc=%0d beats=%0d required 1 0 4 1", d, e, lat, wq.size());
    end
    run_cmd(0, 16'h0600, 8'd1, 1, d, e, lat);
    total++; if (d !== 1'b1 || rq.size() != 1 || rq[0] !== 32'h600D_F00D || rlq[0] !== 1'b1) begin
      bad++; $display("FAIL post_reset_rd: done=%b beats=%0d data=%h required 1 1 600df00d", d, rq.size(), (rq.size() > 0) ? rq[0] : 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) smem[i] = init_val(i);
    ARESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_burst = 0;
    wd_data = '0; wd_valid = 0; rd_ready = 0; AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = 0; RLAST = 0;
    defaults();
    test_reset();
    test_write_basic();
    test_read_basic();
    test_stall();
    test_errors();
    test_len_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
